// File: rtl/count_sequencer.sv
// Command-driven sequencer that issues load and prescaled increment strobes to an external counter.
// LOAD issues one load strobe; RUN issues N increment strobes spaced prescale+1 cycles apart.
module count_sequencer #(
   parameter int WIDTH = 8,
   parameter int PSC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic [PSC_W-1:0] prescale,
   input  logic             hold,
   input  logic             abort,
   output logic             cnt_en,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_val,
   output logic [WIDTH-1:0] remaining,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic [WIDTH-1:0] load_val_q, load_val_d;
   logic [PSC_W-1:0] presc_q, presc_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic             done_q, done_d;
   logic             accept;
   logic             step;

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
   assign cmd_ready    = (state_q == ST_IDLE) && !rst && !abort;
   assign accept       = cmd_valid && cmd_ready;
   assign step         = (state_q == ST_RUN) && !rst && !hold && !abort && (presc_q == psc_q);
   assign cnt_en       = step;
   assign cnt_load     = (state_q == ST_LOAD) && !rst && !abort;
   assign busy         = (state_q != ST_IDLE) && !rst;
   assign done         = done_q;
   assign remaining    = remaining_q;
   assign cnt_load_val = load_val_q;
   assign dbg_state    = state_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      load_val_d  = load_val_q;
      presc_d     = presc_q;
      psc_d       = psc_q;
      done_d      = 1'b0;
      if (abort) begin
         state_d     = ST_IDLE;
         remaining_d = '0;
         presc_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (cmd_op == OP_LOAD) begin
                     load_val_d = cmd_arg;
                     state_d    = ST_LOAD;
                  end else if (cmd_op == OP_RUN) begin
                     if (cmd_arg == '0) begin
                        done_d = 1'b1;
                     end else begin
                        remaining_d = cmd_arg;
                        psc_d       = prescale;
                        presc_d     = '0;
                        state_d     = ST_RUN;
                     end
                  end
               end
            end
            ST_LOAD: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
            ST_RUN: begin
               // hold freezes both the prescale phase and the step count
               if (!hold) begin
                  if (presc_q == psc_q) begin
                     presc_d     = '0;
                     remaining_d = remaining_q - WIDTH'(1);
                     if (remaining_q == WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     presc_d = presc_q + PSC_W'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         load_val_q  <= '0;
         presc_q     <= '0;
         psc_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         load_val_q  <= load_val_d;
         presc_q     <= presc_d;
         psc_q       <= psc_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, sets the width of the counter datapath, run length and load value.
REQ-002 Parameter PSC_W, default 16, sets the prescale field width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_op  input  2  00=LOAD, 01=RUN, 10/11=reserved.
REQ-008 cmd_arg  input  WIDTH  LOAD value or RUN step count N.
REQ-009 prescale  input  PSC_W  RUN step spacing minus one, sampled at acceptance.
REQ-010 hold  input  1  level; freezes a RUN in progress.
REQ-011 abort  input  1  level; cancels any operation.
REQ-012 cnt_en  output  1  one-cycle increment strobe to the counter.
REQ-013 cnt_load  output  1  one-cycle load strobe to the counter.
REQ-014 cnt_load_val  output  WIDTH  load value, valid while cnt_load=1.
REQ-015 remaining  output  WIDTH  RUN steps not yet issued.
REQ-016 busy  output  1  high in LOAD or RUN.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, LOAD, RUN; busy = (state != IDLE).
REQ-019 cmd_ready SHALL be 1 only in IDLE with rst=0 and abort=0; the block SHALL NOT accept a command in any other condition.
REQ-020 Accepted LOAD: latch cmd_arg into cnt_load_val; go to LOAD; in LOAD, cnt_load=1 for exactly one cycle; then IDLE with done=1 in the following cycle.
REQ-021 Accepted RUN, N>0: remaining<=N, latch prescale into psc_q, prescale counter presc<=0, go to RUN.
REQ-022 Accepted RUN, N=0: stay IDLE; done=1 in the next cycle; no cnt_en.
REQ-023 Reserved ops: accepted, no state change, no strobe, no done.
REQ-024 In RUN: cnt_en = !hold && !abort && (presc == psc_q), combinational from registers and inputs.
REQ-025 In RUN with hold=0: if presc==psc_q then presc<=0 and remaining<=remaining-1, else presc<=presc+1.
REQ-026 In RUN with hold=1: presc and remaining frozen, cnt_en=0; resume from the frozen value when hold falls.
REQ-027 The strobe that takes remaining from 1 to 0 SHALL move the FSM to IDLE; done=1 in the next cycle.
REQ-028 RUN with hold never asserted SHALL last exactly N*(psc_q+1) cycles; the k-th cnt_en (k=1..N) SHALL occur in RUN cycle k*(psc_q+1)-1, counting from 0.
REQ-029 psc_q=0: cnt_en high on every RUN cycle.
REQ-030 Changes to prescale after acceptance SHALL NOT affect a run in progress.
REQ-031 abort=1 in any state: cnt_en=0 and cnt_load=0 in that cycle; next state IDLE; remaining<=0; presc<=0; no done pulse; any pending done is suppressed.
REQ-032 done, cnt_en and cnt_load are never high for more than one consecutive cycle per event; cnt_en and cnt_load are never high together.
REQ-033 In IDLE: cnt_en=0, cnt_load=0.

Reset
REQ-034 rst=1 SHALL force state=IDLE, remaining=0, presc=0, psc_q=0, cnt_load_val=0, done=0, cnt_en=0, cnt_load=0, busy=0 and cmd_ready=0; this takes priority over abort, hold and commands.
REQ-035 rst=1 mid-RUN or mid-LOAD SHALL drop the operation with no done pulse; cmd_ready=1 in the first cycle after rst falls.

Verification
REQ-036 LOAD arg=0x5A -> cnt_load=1 with cnt_load_val=0x5A on the cycle after acceptance; done=1 one cycle later; busy high for 1 cycle.
REQ-037 RUN N=3, prescale=2 -> cnt_en in RUN cycles 2, 5 and 8; remaining steps 3,2,1,0; busy for 9 cycles; done on the next cycle.
REQ-038 RUN N=4, prescale=0, hold=1 for RUN cycles 1-3 -> cnt_en in cycles 0, 4, 5 and 6; busy for 7 cycles; remaining frozen at 3 during hold.
REQ-039 RUN N=10, prescale=1, abort at RUN cycle 5 -> cnt_en=0 that cycle; IDLE next cycle; remaining=0; no done pulse; cmd_ready=1.
REQ-040 RUN N=0 -> done pulse next cycle, no cnt_en; and RUN N=255, prescale=0 -> exactly 255 consecutive cnt_en strobes.
REQ-041 rst asserted at RUN cycle 3 of N=5 -> all outputs at their reset values; no done pulse; new LOAD is accepted after rst falls.
